// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data line-fill memory arbiter.
package arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

  localparam int unsigned ARB_LINE_W_DEFAULT = 256;

  // Mask that clears the byte-offset bits of a line address.
  function automatic logic [31:0] align_mask(input int unsigned off_w);
    return ~((32'd1 << off_w) - 32'd1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for mem_arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise the data side always wins.
module arb_pick
  import arb_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_req_t last_grant,
  output logic     grant_valid,
  output arb_req_t grant_id
);

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the side that did not win last time is granted.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_I;
    if (i_req && d_req) begin
      grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      grant_id = REQ_D;
    end else begin
      grant_id = REQ_I;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Data misses stall the whole pipeline, so the data side takes every contention.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_I;
    if (d_req) begin
      grant_id = REQ_D;
    end else begin
      grant_id = REQ_I;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-cache and D-cache line misses onto one physical memory port.
// Contention policy is chosen in arb_pick via ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import arb_types::*;
#(
  parameter int unsigned LINE_W = ARB_LINE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned OFF_W     = $clog2(LINE_W / 8);
  localparam logic [31:0] ADDR_MASK = align_mask(OFF_W);

  arb_state_t state_q, state_d;
  arb_req_t   last_grant_q, last_grant_d;
  logic       grant_valid_s;
  arb_req_t   grant_id_s;
  logic       serve_i_s, serve_d_s;

  arb_pick u_pick (
    .i_req       (i_read),
    .d_req       (d_read | d_write),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Next-state: grant only from IDLE, hold the grant until the memory responds.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d      = (grant_id_s == REQ_D) ? SERVE_D : SERVE_I;
          last_grant_d = grant_id_s;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant-history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs are silenced while rst is high so an aborted transfer never completes.
  assign serve_i_s = (state_q == SERVE_I) && !rst;
  assign serve_d_s = (state_q == SERVE_D) && !rst;

  // Strobe decode and response routing from the registered state.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = 32'd0;
    pmem_wdata = '0;
    i_rdata    = '0;
    i_resp     = 1'b0;
    d_rdata    = '0;
    d_resp     = 1'b0;
    if (serve_i_s) begin
      pmem_read = 1'b1;
      pmem_addr = i_addr & ADDR_MASK;
      i_resp    = pmem_resp;
      i_rdata   = pmem_rdata;
    end else if (serve_d_s) begin
      pmem_write = d_write;
      pmem_read  = d_read & ~d_write;
      pmem_addr  = d_addr & ADDR_MASK;
      pmem_wdata = d_wdata;
      d_resp     = pmem_resp;
      d_rdata    = pmem_rdata;
    end else begin
      pmem_read = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants, a monitor checks them.
module tb_mem_arbiter;

  localparam int LW = 256;

  logic          clk, rst;
  logic          i_read, i_resp, d_read, d_write, d_resp;
  logic [31:0]   i_addr, d_addr, pmem_addr;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
  logic          pmem_read, pmem_write, pmem_resp;

  mem_arbiter #(.LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit            side;   // 0 = instruction, 1 = data
    bit            rd;
    bit            wr;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            start;
  } item_t;

  item_t exp_q[$];
  item_t cur;
  bit    cur_v;

  logic [LW-1:0] ref_mem [logic [31:0]];
  logic [LW-1:0] pm_mem  [logic [31:0]];

  int total, bad, cyc;
  int drv_i, drv_d;
  bit i_done, d_done;
  bit m_busy, m_last;
  bit rand_en, stop_new, mem_hold, stray_force;
  int lat_fixed, mem_cnt, mem_lat, i_gap, d_gap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] dflt(input logic [31:0] a);
    return {8{a ^ 32'hC3C3_0000}};
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h4000_0000 | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
  endfunction

  // Reference model: one transaction at a time, chosen only when the port is free.
  task automatic model();
    item_t it;
    bit ip, dp, win;
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b0;
      exp_q.delete();
      return;
    end
    if (m_busy) begin
      if (pmem_resp) m_busy = 1'b0;
      return;
    end
    ip = i_read;
    dp = d_read | d_write;
    if (!(ip || dp)) return;
    if (ip && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~m_last;
`else
      win = 1'b1;
`endif
    end else begin
      win = dp;
    end
    it.side  = win;
    it.wr    = win ? d_write : 1'b0;
    it.rd    = win ? (d_read && !d_write) : 1'b1;
    it.addr  = (win ? d_addr : i_addr) & 32'hFFFF_FFE0;
    it.wdata = win ? d_wdata : '0;
    it.start = cyc + 1;
    if (it.wr) begin
      ref_mem[it.addr] = it.wdata;
      it.rdata = '0;
    end else begin
      it.rdata = ref_mem.exists(it.addr) ? ref_mem[it.addr] : dflt(it.addr);
    end
    exp_q.push_back(it);
    m_busy = 1'b1;
    m_last = win;
  endtask

  // Downstream memory: responds after a latency, or fires a stray response while idle.
  task automatic mem_drive();
    logic [31:0] r;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    if (rst) begin
      mem_cnt = 0;
    end else if (pmem_read || pmem_write) begin
      if (mem_cnt == 0) mem_lat = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
      if (!mem_hold && mem_cnt >= mem_lat) begin
        pmem_resp = 1'b1;
        if (pmem_write) pm_mem[pmem_addr] = pmem_wdata;
        else pmem_rdata = pm_mem.exists(pmem_addr) ? pm_mem[pmem_addr] : dflt(pmem_addr);
        mem_cnt = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
      if (stray_force || (rand_en && $urandom_range(0, 7) == 0)) begin
        r = $urandom;
        pmem_resp  = 1'b1;
        pmem_rdata = {8{r | 32'h1}};
      end
    end
  endtask

  task automatic agents();
    int op;
    if (i_read && i_done) begin
      i_read = 1'b0;
      i_gap  = $urandom_range(0, 3);
    end else if (!i_read) begin
      if (i_gap > 0) i_gap--;
      else if (!stop_new && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_addr = rand_addr();
      end
    end
    if ((d_read || d_write) && d_done) begin
      d_read  = 1'b0;
      d_write = 1'b0;
      d_gap   = $urandom_range(0, 3);
    end else if (!(d_read || d_write)) begin
      if (d_gap > 0) d_gap--;
      else if (!stop_new && $urandom_range(0, 1) == 0) begin
        op      = $urandom_range(0, 9);
        d_write = (op < 4);
        d_read  = (op >= 3);
        d_addr  = rand_addr();
        d_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic settle();
    mem_drive();
    #1;
    model();
    i_done = i_resp;
    d_done = d_resp;
    drv_i += int'(i_resp);
    drv_d += int'(d_resp);
  endtask

  task automatic step();
    tick();
    if (rand_en) agents();
    settle();
  endtask

  task automatic wait_done(input bit side, input string name);
    int n;
    n = 0;
    while (!(side ? d_done : i_done) && n < 40) begin
      step();
      n++;
    end
    chk(name, side ? d_done : i_done, 1'b1);
  endtask

  task automatic quiet_chk(input string pfx);
    chk({pfx, "_strobe_resp"}, {pmem_read, pmem_write, i_resp, d_resp}, '0);
    chk({pfx, "_addr"}, pmem_addr, '0);
    chk({pfx, "_wdata"}, pmem_wdata, '0);
    chk({pfx, "_rdata"}, i_rdata | d_rdata, '0);
  endtask

  // Monitor: pops the expected transaction when the port starts a transfer and follows it to completion.
  initial begin
    bit strobe;
    forever begin
      @(negedge clk);
      #2;
      strobe = pmem_read | pmem_write;
      if (rst) begin
        quiet_chk("rst");
        cur_v = 1'b0;
      end else begin
        if (strobe && !cur_v) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_txn", {pmem_read, pmem_write}, '0);
          end else begin
            cur   = exp_q.pop_front();
            cur_v = 1'b1;
            chk("start_cycle", LW'(cyc), LW'(cur.start));
          end
        end
        if (cur_v && strobe) begin
          chk("op", {pmem_read, pmem_write}, {cur.rd, cur.wr});
          chk("addr", pmem_addr, cur.addr);
          chk("wdata", pmem_wdata, cur.wdata);
          chk("resp_route", {i_resp, d_resp}, cur.side ? {1'b0, pmem_resp} : {pmem_resp, 1'b0});
          chk("rdata_other", cur.side ? i_rdata : d_rdata, '0);
          chk("rdata_own", cur.side ? d_rdata : i_rdata, pmem_rdata);
          if (pmem_resp) begin
            chk("resp_data", cur.side ? d_rdata : i_rdata, cur.rdata);
            cur_v = 1'b0;
          end
        end else if (!strobe) begin
          if (cur_v) begin
            chk("txn_dropped", 1'b0, 1'b1);
            cur_v = 1'b0;
          end
          quiet_chk("idle");
        end
      end
    end
  end

  initial begin
    int n, ci, cd, sc, d0;
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    pm_mem[32'h0000_1220]  = a5;
    ref_mem[32'h0000_1220] = a5;
    total = 0; bad = 0; cyc = 0; drv_i = 0; drv_d = 0;
    rand_en = 0; stop_new = 0; mem_hold = 0; stray_force = 0; lat_fixed = 5;
    rst = 1'b1;
    i_read = 1'b1; i_addr = 32'h0000_1234;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'd0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;

    // Reset held with a pending I request, then a single I read with 5-cycle latency.
    repeat (3) step();
    tick(); rst = 1'b0; settle();
    wait_done(1'b0, "i_read_done");
    tick(); i_read = 1'b0; settle();
    chk("i_resp_count", LW'(drv_i), LW'(1));
    chk("d_resp_none", LW'(drv_d), LW'(0));

    // Write-back.
    lat_fixed = 3;
    tick(); d_write = 1'b1; d_addr = 32'h8000_00E4; d_wdata = LW'(1); settle();
    wait_done(1'b1, "wb_done");
    tick(); d_write = 1'b0; settle();

    // Stray responses while idle.
    tick(); stray_force = 1'b1; settle();
    step();
    tick(); stray_force = 1'b0; settle();

    // Fresh reset so the grant history starts at I, then continuous contention.
    tick(); rst = 1'b1; settle();
    tick(); rst = 1'b0; settle();
    lat_fixed = 0;
    ci = drv_i; cd = drv_d; n = 0;
    tick(); i_read = 1'b1; i_addr = 32'h1000_0040; d_read = 1'b1; d_addr = 32'h2000_0080; settle();
    while ((drv_i - ci) + (drv_d - cd) < 8 && n < 200) begin
      step();
      n++;
    end
    tick(); i_read = 1'b0; d_read = 1'b0; settle();
`ifdef ARB_ROUND_ROBIN_EN
    chk("contend_i", LW'(drv_i - ci), LW'(4));
    chk("contend_d", LW'(drv_d - cd), LW'(4));
`else
    chk("contend_i", LW'(drv_i - ci), LW'(0));
    chk("contend_d", LW'(drv_d - cd), LW'(8));
`endif
    step();

    // Reset during the second cycle of a data read; a later response must be ignored.
    mem_hold = 1'b1; d0 = drv_d; sc = 0; n = 0;
    tick(); d_read = 1'b1; d_addr = 32'h3000_0100; settle();
    while (!rst && n < 20) begin
      tick();
      if (pmem_read) sc++;
      if (sc == 2) rst = 1'b1;
      settle();
      n++;
    end
    chk("abort_reached", rst, 1'b1);
    tick(); rst = 1'b0; d_read = 1'b0; mem_hold = 1'b0; settle();
    tick(); stray_force = 1'b1; settle();
    tick(); stray_force = 1'b0; settle();
    chk("abort_no_dresp", LW'(drv_d - d0), LW'(0));

    // Randomized traffic, then drain.
    lat_fixed = -1; i_gap = 0; d_gap = 0; rand_en = 1'b1;
    repeat (1500) step();
    stop_new = 1'b1;
    repeat (80) step();
    tick(); #3;
    chk("drain", LW'(exp_q.size() + int'(cur_v)), LW'(0));
    chk("req_idle", {i_read, d_read, d_write}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
